// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// FSM states, ALU-op classes and ALU control codes.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_aludec.sv
// ALU decoder: maps the FSM's aluop class and the instruction funct field
// to an ALU control code. Unknown funct values fall back to add.
module multicycle_aludec
  import multicycle_controller_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  aluop_t               aluop,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [2:0]           alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath with memready stalls on
// instruction fetch and data accesses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | read instr at PC, PC += 4; waits for memready
// DECODE    | precompute branch target, dispatch on opcode
// MEMADR    | ALUOut = A + sign-extended immediate
// MEMRD     | read data memory at ALUOut; waits for memready
// MEMWB     | rt <= data register
// MEMWR     | write data memory at ALUOut; waits for memready
// RTYPEEX   | ALUOut = A op B
// RTYPEWB   | rd <= ALUOut
// BEQEX     | compare A, B; take branch target on zero
// ADDIEX    | ALUOut = A + sign-extended immediate
// ADDIWB    | rt <= ALUOut
// JEX       | PC <= jump target
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               memready,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pcen,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   pcwrite, branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = S_FETCH;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
        state_d = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            // PC already advanced in FETCH, so returning skips the bad word
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = memready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Write enables must not glitch through while reset holds the FSM
    if (reset) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = STATE_W'(state_q);

  multicycle_aludec #(.FUNCT_W(FUNCT_W)) u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: table of instructions plus random ones,
// each checked cycle by cycle against a timeline model of the instruction.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite;
  logic       alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_cmp = 0;
  int n_fail = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .pcen(pcen), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         sf;
    int         sm;
    int         len;
    logic [2:0] alu;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] o);
    return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
           o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
  endfunction

  function automatic int base_len(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000100) return 3'b110;
    if (o != 6'b000000) return 3'b010;
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Instruction timeline: fetch ends at cycle sf+1, the memory phase of
  // lw/sw starts at cycle sf+4 and lasts sm+1 cycles, write-back is last.
  function automatic logic [5:0] ref_wen(input logic [5:0] o, input logic z,
                                         input int sf, input int sm, input int len,
                                         input int k);
    logic irw, pc, rw, mw, io, il;
    bit   is_lw, is_sw;
    is_lw = (o == 6'b100011);
    is_sw = (o == 6'b101011);
    irw = (k == sf + 1);
    pc  = (k == sf + 1) || (k == sf + 3 && ((o == 6'b000100 && z) || o == 6'b000010));
    rw  = (is_lw || o == 6'b000000 || o == 6'b001000) && k == len;
    mw  = is_sw && k >= sf + 4;
    io  = (is_lw && k >= sf + 4 && k <= sf + 4 + sm) || (is_sw && k >= sf + 4);
    il  = !legal(o) && k == sf + 2;
    return {irw, pc, rw, mw, io, il};
  endfunction

  function automatic logic mr_for(input logic [5:0] o, input int sf, input int sm, input int k);
    bit is_mem;
    is_mem = (o == 6'b100011 || o == 6'b101011);
    if (k <= sf) return 1'b0;
    if (k == sf + 1) return 1'b1;
    if (is_mem && k >= sf + 4 && k < sf + 4 + sm) return 1'b0;
    if (is_mem && k == sf + 4 + sm) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int sf, input int sm, input int len,
                           input logic [2:0] alu, input string tag);
    for (int k = 1; k <= len; k++) begin
      op       = o;
      funct    = f;
      zero     = z;
      memready = mr_for(o, sf, sm, k);
      @(negedge clk);
      if (k == 1) chk({tag, " start_state"}, 32'(state), 32'(0));
      if (k == sf + 2 && len > sf + 1) chk({tag, " decode_state"}, 32'(state), 32'(1));
      chk($sformatf("%s wen k=%0d", tag, k),
          32'({irwrite, pcen, regwrite, memwrite, iord, illegal}),
          32'(ref_wen(o, z, sf, sm, len, k)));
      if (k == sf + 1) chk({tag, " fetch_alu"}, 32'({alucontrol, alusrcb}), 32'({3'b010, 2'b01}));
      if (k == sf + 3 && (o == 6'b000000 || o == 6'b000100))
        chk({tag, " exec_alu"}, 32'(alucontrol), 32'(alu));
      if (k == sf + 3 && o == 6'b000100) chk({tag, " beq_pcsrc"}, 32'(pcsrc), 32'(2'b01));
      if (k == sf + 3 && o == 6'b000010) chk({tag, " j_pcsrc"}, 32'(pcsrc), 32'(2'b10));
      if (k == len && o == 6'b000000) chk({tag, " rtype_regdst"}, 32'(regdst), 32'(1));
      if (k == len && o == 6'b100011) chk({tag, " lw_memtoreg"}, 32'(memtoreg), 32'(1));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] o, f;
    int sf, sm, sel;

    tbl[0]  = '{6'b100011, 6'b000000, 1'b0, 0, 0, 5,  3'b010};
    tbl[1]  = '{6'b000000, 6'b100101, 1'b0, 0, 0, 4,  3'b001};
    tbl[2]  = '{6'b000100, 6'b000000, 1'b1, 0, 0, 3,  3'b110};
    tbl[3]  = '{6'b000100, 6'b000000, 1'b0, 0, 0, 3,  3'b110};
    tbl[4]  = '{6'b001000, 6'b000000, 1'b0, 3, 0, 7,  3'b010};
    tbl[5]  = '{6'b101011, 6'b000000, 1'b0, 0, 2, 6,  3'b010};
    tbl[6]  = '{6'b111111, 6'b000000, 1'b0, 0, 0, 2,  3'b010};
    tbl[7]  = '{6'b000010, 6'b000000, 1'b1, 0, 0, 3,  3'b010};
    tbl[8]  = '{6'b000000, 6'b111111, 1'b0, 0, 0, 4,  3'b010};
    tbl[9]  = '{6'b000000, 6'b100010, 1'b1, 1, 0, 5,  3'b110};
    tbl[10] = '{6'b000000, 6'b100100, 1'b0, 0, 0, 4,  3'b000};
    tbl[11] = '{6'b000000, 6'b101010, 1'b0, 0, 0, 4,  3'b111};
    tbl[12] = '{6'b100011, 6'b000000, 1'b0, 2, 3, 10, 3'b010};

    reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b1; memready = 1'b1;
    #3;
    chk("reset_state", 32'(state), 32'(0));
    chk("reset_wen", 32'({irwrite, pcen, regwrite, memwrite, illegal}), 32'(0));
    chk("reset_mux", 32'({iord, alusrca, alusrcb, pcsrc, alucontrol, regdst, memtoreg}),
        32'({1'b0, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0}));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].sf, tbl[i].sm,
                tbl[i].len, tbl[i].alu, $sformatf("vec%0d", i));

    // reset in the middle of a stalled store
    for (int k = 1; k <= 4; k++) begin
      op = 6'b101011; memready = (k == 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (k < 4) begin
        @(posedge clk);
        #1;
      end
    end
    chk("memwr_before_reset", 32'({memwrite, state}), 32'({1'b1, 4'd5}));
    #2 reset = 1'b1;
    #1;
    chk("memwr_reset_async", 32'({memwrite, state}), 32'({1'b0, 4'd0}));
    memready = 1'b1;
    #1;
    chk("reset_irwrite_forced", 32'({irwrite, pcen}), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(6'b001000, 6'b0, 1'b0, 0, 0, 4, 3'b010, "after_reset");

    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000000;
        3: o = 6'b000100;
        4: o = 6'b001000;
        5: o = 6'b000010;
        default: begin
          o = 6'($urandom_range(0, 63));
          for (int t = 0; t < 64 && legal(o); t++) o = o + 6'd1;
        end
      endcase
      case ($urandom_range(0, 5))
        0: f = 6'b100000;
        1: f = 6'b100010;
        2: f = 6'b100100;
        3: f = 6'b100101;
        4: f = 6'b101010;
        default: f = 6'($urandom_range(0, 63));
      endcase
      sf = int'($urandom_range(0, 3));
      sm = (o == 6'b100011 || o == 6'b101011) ? int'($urandom_range(0, 3)) : 0;
      run_instr(o, f, 1'($urandom_range(0, 1)), sf, sm, base_len(o) + sf + sm,
                ref_alu(o, f), $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    chk("final_state", 32'(state), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
